// File: rtl/dual_fetch_unit.sv
// Dual-slot instruction fetch: reads PC/PC+1 each cycle, resolves slot jumps, holds on decode backpressure.
// Optional macro NOP_SQUASH_EN: NOP-opcode slots are delivered with their valid cleared.
module dual_fetch_unit #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk1,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr0,
    output logic [PC_W-1:0]    imem_addr1,
    input  logic [INSTR_W-1:0] imem_data0,
    input  logic [INSTR_W-1:0] imem_data1,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               if_valid0,
    output logic               if_valid1,
    output logic [INSTR_W-1:0] if_instr0,
    output logic [INSTR_W-1:0] if_instr1,
    output logic [PC_W-1:0]    if_pc0,
    output logic [PC_W-1:0]    if_pc1
);
    localparam int unsigned        OP_W     = 6;
    localparam logic [OP_W-1:0]    OP_J     = 6'b100000;
    localparam logic [OP_W-1:0]    OP_NOP   = 6'b111111;
    localparam logic [INSTR_W-1:0] NOP_WORD = {OP_NOP, {(INSTR_W-OP_W){1'b0}}};
`ifdef NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;
    state_t state;

    logic [OP_W-1:0] op0;
    logic [OP_W-1:0] op1;
    logic            slot_v0;
    logic            slot_v1;
    logic [PC_W-1:0] fetch_next;
    logic            hold;

    // Slot qualification and next-PC selection for the pair currently on the memory bus
    always_comb begin
        op0        = imem_data0[31:26];
        op1        = imem_data1[31:26];
        slot_v0    = 1'b1;
        slot_v1    = 1'b1;
        fetch_next = imem_addr0 + PC_W'(2);
        if (op0 == OP_J) begin
            slot_v0    = 1'b0;
            slot_v1    = 1'b0;
            fetch_next = imem_data0[PC_W-1:0];
        end else if (op1 == OP_J) begin
            slot_v1    = 1'b0;
            fetch_next = imem_data1[PC_W-1:0];
        end
        if (SQUASH && (op0 == OP_NOP)) slot_v0 = 1'b0;
        if (SQUASH && (op1 == OP_NOP)) slot_v1 = 1'b0;
        hold = (if_valid0 | if_valid1) & ~id_ready;
    end

    // imem_addr0 is the architectural PC; imem_addr1 tracks PC+1 so both address ports are registered
    always_ff @(posedge clk1) begin
        if (reset) begin
            state      <= IDLE;
            imem_addr0 <= '0;
            imem_addr1 <= PC_W'(1);
            if_valid0  <= 1'b0;
            if_valid1  <= 1'b0;
            if_instr0  <= NOP_WORD;
            if_instr1  <= NOP_WORD;
            if_pc0     <= '0;
            if_pc1     <= '0;
        end else if (redirect_valid) begin
            state      <= FETCH;
            imem_addr0 <= redirect_pc;
            imem_addr1 <= redirect_pc + PC_W'(1);
            if_valid0  <= 1'b0;
            if_valid1  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH, STALL: begin
                    if (hold) begin
                        state <= STALL;
                    end else begin
                        state      <= FETCH;
                        if_valid0  <= slot_v0;
                        if_valid1  <= slot_v1;
                        if_instr0  <= imem_data0;
                        if_instr1  <= imem_data1;
                        if_pc0     <= imem_addr0;
                        if_pc1     <= imem_addr1;
                        imem_addr0 <= fetch_next;
                        imem_addr1 <= fetch_next + PC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dual_fetch_unit.md
DUAL_FETCH_UNIT -- requirements
Module: dual_fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning word-address width of the instruction memory (1024 words).
REQ-002 SHALL have parameter INSTR_W, default 32, meaning instruction width.
REQ-003 SHALL have port clk1  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports imem_addr0 / imem_addr1  output  PC_W each  read addresses PC and PC+1.
REQ-006 SHALL have ports imem_data0 / imem_data1  input  INSTR_W each  same-cycle read data for imem_addr0 / imem_addr1.
REQ-007 SHALL have ports redirect_valid  input  1  and redirect_pc  input  PC_W  branch-resolve redirect from EX.
REQ-008 SHALL have port id_ready  input  1  decode accepts the current pair.
REQ-009 SHALL have ports if_valid0 / if_valid1  output  1 each  slot valid flags.
REQ-010 SHALL have ports if_instr0 / if_instr1  output  INSTR_W each  registered instruction words.
REQ-011 SHALL have ports if_pc0 / if_pc1  output  PC_W each  address of each slot.

Function
REQ-012 SHALL implement an FSM with states IDLE, FETCH, STALL.
REQ-013 IDLE SHALL last exactly one cycle after reset deasserts, capture nothing, then go to FETCH.
REQ-014 In FETCH, each cycle SHALL load the output registers with {imem_data0, PC} and {imem_data1, PC+1}; latency from PC to outputs is one cycle.
REQ-015 Opcode = instr[31:26]; J = 6'b100000, NOP = 6'b111111.
REQ-016 If slot0 is J: if_valid0=0, if_valid1=0, next PC = instr0[PC_W-1:0] (absolute target).
REQ-017 If slot0 is not J and slot1 is J: if_valid0=1, if_valid1=0, next PC = instr1[PC_W-1:0].
REQ-018 Otherwise both slots valid and next PC = PC+2.
REQ-019 PC, PC+1 and PC+2 SHALL wrap modulo 2^PC_W; odd jump targets fetch unaligned pairs (target, target+1) with no alignment penalty.
REQ-020 When output registers hold any valid slot and id_ready=0, FSM SHALL enter STALL; outputs and PC held unchanged.
REQ-021 STALL -> FETCH in the cycle id_ready=1; the held pair is consumed on that edge and a new pair loaded.
REQ-022 An all-invalid output pair SHALL never cause STALL (id_ready ignored).
REQ-023 redirect_valid=1 SHALL take priority over J, stall and id_ready: next edge PC <= redirect_pc, both valids <= 0, FSM <= FETCH.
REQ-024 redirect_valid asserted during IDLE SHALL load PC and still end IDLE normally.

Reset
REQ-025 reset=1 at an edge SHALL set PC=0, FSM=IDLE, if_valid0/1=0, if_instr0/1={NOP,26'd0}, if_pc0/1=0, overriding redirect and any stall.
REQ-026 imem_addr0/imem_addr1 SHALL read 0/1 during and after reset until the first PC update.

Configuration
REQ-027 Macro NOP_SQUASH_EN: when defined, any slot whose opcode is NOP SHALL be delivered with its valid=0 (PC sequencing unchanged); when undefined, NOP slots are delivered valid=1 like any non-J instruction.

Verification
REQ-028 Memory: 0 ADD R1,R2,R14; 1 ADD; 2 ADD; 3 J 10; 14..17 ADD; rest NOP; id_ready=1, macro undefined -> pairs (0,1 v=1,1), (2,3 v=1,0), (10,11), (12,13), (14,15), (16,17) on consecutive cycles after IDLE.
REQ-029 Same program, NOP_SQUASH_EN defined -> pairs at 10/11 and 12/13 have valid=0,0; pair 14/15 valid=1,1 on same cycle as REQ-028.
REQ-030 J 10 at address 2 (slot0) -> pair (2,3) valid=0,0; next pair PC 10.
REQ-031 id_ready=0 for 3 cycles while pair (2,3) is held -> outputs and imem_addr0=4 frozen, FSM=STALL; on release pair (4,5) next cycle.
REQ-032 redirect_valid=1, redirect_pc=1023 during STALL -> next cycle valids 0, then pair (1023,0) wraps.
REQ-033 reset=1 asserted mid-stall for one cycle -> all outputs at reset values, IDLE one cycle, then pair (0,1).
